// File: rtl/serial_dff_tx.sv
// serial_dff_tx: parallel-in, serial-out transmitter that drives the d/clk
// pins of a rising-edge master-slave D flip-flop chain, MSB first, and then
// pulses a latch-enable strobe so a downstream latch bank captures the word.
// Everything runs in the system clock domain; sclk is a divided, registered
// copy whose half-period is DIV system-clock cycles.
module serial_dff_tx #(
  parameter int WIDTH = 8,  // bits per frame, >= 2
  parameter int DIV   = 2   // system cycles per sclk half-period, >= 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sdata,
  output logic             sclk,
  output logic             sload,
  output logic             busy,
  output logic             done
);

  // Counter widths; a single-value range still needs one bit.
  localparam int DW = (DIV   > 1) ? $clog2(DIV)   : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  // LOW and HIGH are the two sclk half-periods of one bit; STROBE holds
  // sload for one half-period after the final falling sclk edge.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOW    = 2'd1,
    HIGH   = 2'd2,
    STROBE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [DW-1:0]    div_cnt, div_nxt;
  logic [BW-1:0]    bit_cnt, bit_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             sclk_nxt;
  logic             sload_nxt;
  logic             done_nxt;
  logic             div_end;
  logic             accept;

  // sdata is the top bit of the shift register, so it is registered and
  // changes exactly when the register loads, shifts, or clears.
  assign sdata = shreg[WIDTH-1];

  // Handshake and status are decoded straight from state. Holding load_ready
  // low while rst_n is low keeps the source from believing a word was taken
  // on an edge that the reset branch will discard.
  assign load_ready = (state == IDLE) && rst_n;
  assign busy       = (state != IDLE);
  assign accept     = load_valid && load_ready;
  assign div_end    = (div_cnt == DIV_LAST);

  // State and datapath registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  // NOTE: the shift register is an ordinary flop bank, not a memory, so it is
  // reset along with the rest; that also forces sdata low out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sclk    <= 1'b0;
      sload   <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= shreg_nxt;
      sclk    <= sclk_nxt;
      sload   <= sload_nxt;
      done    <= done_nxt;
    end
  end

  // Next-state logic: each non-idle state lasts DIV system cycles.
  // NOTE: every combinational output gets a default first so no path through
  // the case statement leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = LOW;
      end
      LOW: begin
        if (div_end) state_nxt = HIGH;
      end
      HIGH: begin
        if (div_end) state_nxt = (bit_cnt == BIT_LAST) ? STROBE : LOW;
      end
      STROBE: begin
        if (div_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the counters and registered outputs for each state.
  always_comb begin
    div_nxt   = div_cnt + DW'(1);
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    sclk_nxt  = sclk;
    sload_nxt = sload;
    done_nxt  = 1'b0;

    unique case (state)
      IDLE: begin
        // The divider idles at zero so the first LOW half-period is full.
        div_nxt = '0;
        if (accept) begin
          shreg_nxt = load_data;
          bit_nxt   = '0;
        end
      end

      LOW: begin
        // Bit has been stable for DIV cycles; raise the receiver clock.
        if (div_end) begin
          div_nxt  = '0;
          sclk_nxt = 1'b1;
        end
      end

      HIGH: begin
        // Falling sclk is the only in-frame point where sdata may move,
        // giving DIV cycles of hold after the rise and setup before the next.
        if (div_end) begin
          div_nxt  = '0;
          sclk_nxt = 1'b0;
          if (bit_cnt == BIT_LAST) begin
            sload_nxt = 1'b1;
          end else begin
            shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
            bit_nxt   = bit_cnt + BW'(1);
          end
        end
      end

      STROBE: begin
        // Close the latch bank, flag completion and park sdata low.
        if (div_end) begin
          div_nxt   = '0;
          sload_nxt = 1'b0;
          done_nxt  = 1'b1;
          shreg_nxt = '0;
        end
      end

      default: begin
        div_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_dff_tx.sv
// Directed bench for serial_dff_tx: an 8-bit/DIV=2 instance and a
// 2-bit/DIV=1 corner instance, each feeding a behavioural D-FF receiver
// chain and latch bank. Cycle numbers count edges after the accept edge E0.
module tb_serial_dff_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (WIDTH=8, DIV=2)
  logic       rst_n, load_valid, load_ready, sdata, sclk, sload, busy, done;
  logic [7:0] load_data;

  // Corner instance (WIDTH=2, DIV=1)
  logic       rst_n_c, load_valid_c, load_ready_c, sdata_c, sclk_c, sload_c, busy_c, done_c;
  logic [1:0] load_data_c;

  serial_dff_tx #(.WIDTH(8), .DIV(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .sdata(sdata), .sclk(sclk), .sload(sload),
    .busy(busy), .done(done)
  );

  serial_dff_tx #(.WIDTH(2), .DIV(1)) u_cor (
    .clk(clk), .rst_n(rst_n_c), .load_valid(load_valid_c), .load_data(load_data_c),
    .load_ready(load_ready_c), .sdata(sdata_c), .sclk(sclk_c), .sload(sload_c),
    .busy(busy_c), .done(done_c)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Behavioural receivers: rising-edge D-FF chain plus output latch bank
  // whose captured value is what remains when the enable closes.
  logic [7:0] chain = '0, bank = '0;
  logic [1:0] chain_c = '0, bank_c = '0;
  always @(posedge sclk)   chain   <= {chain[6:0], sdata};
  always @(negedge sload)  bank    <= chain;
  always @(posedge sclk_c) chain_c <= {chain_c[0], sdata_c};
  always @(negedge sload_c) bank_c <= chain_c;

  // Pulse counters and an sdata-while-sclk-high stability monitor.
  int   sload_cnt = 0, done_cnt = 0, viol = 0;
  logic last_sclk = 1'b0, last_sdata = 1'b0;
  always @(posedge sload) sload_cnt <= sload_cnt + 1;
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;
  always @(negedge clk) begin
    if (last_sclk && sclk && (sdata !== last_sdata)) viol <= viol + 1;
    last_sclk  <= sclk;
    last_sdata <= sdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic send(input logic [7:0] d);
    check("ready_before_send", 32'(load_ready), 32'd1);
    load_data  = d;
    load_valid = 1'b1;
    step();
    cyc        = 0;
    load_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    int gap, ready_hi, s0, d0;
    bit seen_idle;

    // Reset values: reset held 3 cycles with load_valid asserted.
    rst_n = 1'b0; load_valid = 1'b1; load_data = 8'hFF;
    rst_n_c = 1'b0; load_valid_c = 1'b1; load_data_c = 2'b11;
    repeat (3) step();
    check("rst_ready", 32'(load_ready), 0);
    check("rst_busy",  32'(busy),       0);
    check("rst_sclk",  32'(sclk),       0);
    check("rst_sdata", 32'(sdata),      0);
    check("rst_sload", 32'(sload),      0);
    check("rst_done",  32'(done),       0);
    check("rst_c_ready_busy", 32'({load_ready_c, busy_c, sclk_c, sdata_c, sload_c, done_c}), 0);
    rst_n = 1'b1; load_valid = 1'b0;
    rst_n_c = 1'b1; load_valid_c = 1'b0;
    #1;
    check("ready_after_rst", 32'(load_ready), 1);
    step();
    check("no_frame_after_rst", 32'(busy), 0);

    // Single frame 0xA5.
    pat = 8'hA5;
    send(pat);
    check("a5_e0_sdata", 32'(sdata), 1);
    check("a5_e0_busy",  32'(busy),  1);
    for (int k = 0; k < 8; k++) begin
      goto((2 * k + 1) * 2 - 1);
      check($sformatf("a5_sclk_low_%0d", k), 32'(sclk), 0);
      step();
      check($sformatf("a5_sclk_rise_%0d", k), 32'(sclk), 1);
      check($sformatf("a5_bit_%0d", k), 32'(sdata), 32'(pat[7-k]));
    end
    goto(31);
    check("a5_sload_e31", 32'(sload), 0);
    step();
    check("a5_sload_e32", 32'(sload), 1);
    check("a5_done_e32",  32'(done),  0);
    step();
    check("a5_sload_e33", 32'(sload), 1);
    step();
    check("a5_sload_e34", 32'(sload), 0);
    check("a5_done_e34",  32'(done),  1);
    check("a5_ready_e34", 32'(load_ready), 1);
    check("a5_sdata_e34", 32'(sdata), 0);
    check("a5_bank",      32'(bank),  32'hA5);
    step();
    check("a5_done_e35",  32'(done),  0);

    // Back-to-back: valid held high across two frames.
    load_data = 8'h3C; load_valid = 1'b1;
    step();
    cyc = 0;
    load_data = 8'hC3;
    gap = -1; seen_idle = 0;
    for (int i = 0; i < 100 && gap < 0; i++) begin
      step();
      if (!busy) seen_idle = 1;
      else if (seen_idle) gap = cyc;
    end
    check("b2b_gap",    32'(gap),  35);
    check("b2b_bank1",  32'(bank), 32'h3C);
    check("b2b_sdata",  32'(sdata), 1);
    load_valid = 1'b0;
    cyc = 0;
    goto(34);
    check("b2b_done2",  32'(done), 1);
    check("b2b_bank2",  32'(bank), 32'hC3);
    check("b2b_stable", 32'(viol), 0);

    // Busy ignore: 0xFF pulsed at E10 of a 0x00 frame.
    send(8'h00);
    goto(9);
    load_data = 8'hFF; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    ready_hi = 0;
    while (cyc < 34) begin
      if (load_ready) ready_hi++;
      step();
    end
    check("ign_ready_low", 32'(ready_hi), 0);
    check("ign_ready_e34", 32'(load_ready), 1);
    check("ign_bank",      32'(bank), 32'h00);
    step();
    check("ign_no_restart", 32'(busy), 0);

    // Reset at E12 of a 0x5A frame.
    send(8'h5A);
    goto(11);
    s0 = sload_cnt; d0 = done_cnt;
    rst_n = 1'b0;
    step();
    check("mid_rst_outs", 32'({load_ready, busy, sclk, sdata, sload, done}), 0);
    rst_n = 1'b1;
    repeat (40) step();
    check("mid_rst_no_sload", 32'(sload_cnt), 32'(s0));
    check("mid_rst_no_done",  32'(done_cnt),  32'(d0));
    check("mid_rst_bank_kept", 32'(bank), 32'h00);
    send(8'h81);
    goto(34);
    check("post_rst_done", 32'(done), 1);
    check("post_rst_bank", 32'(bank), 32'h81);

    // Corner: WIDTH=2, DIV=1, send 2'b10.
    check("cor_ready", 32'(load_ready_c), 1);
    load_data_c = 2'b10; load_valid_c = 1'b1;
    step();
    cyc = 0;
    load_valid_c = 1'b0;
    check("cor_e0", 32'({sclk_c, sdata_c}), 32'b01);
    goto(1);
    check("cor_e1", 32'({sclk_c, sdata_c}), 32'b11);
    goto(2);
    check("cor_e2", 32'({sclk_c, sdata_c}), 32'b00);
    goto(3);
    check("cor_e3", 32'({sclk_c, sdata_c}), 32'b10);
    goto(4);
    check("cor_e4", 32'({sload_c, done_c, sclk_c}), 32'b100);
    goto(5);
    check("cor_e5", 32'({sload_c, done_c, load_ready_c}), 32'b011);
    goto(6);
    check("cor_e6_done", 32'(done_c), 0);
    check("cor_bank", 32'(bank_c), 32'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
